// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
package mux_seq_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   localparam logic [1:0] SEL_LAST = 2'd3;
   localparam int         DATA_W   = 4;

endpackage

// File: rtl/dwell_counter.sv
// Dwell timer: counts cycles spent on one select value and flags the last one.
module dwell_counter #(
   parameter int CNT_W = 8,
   parameter int DWELL = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   // A zero dwell would never produce a terminal count, and anything past the
   // counter range would wrap before reaching it.
   if (DWELL < 1 || DWELL > (2 ** CNT_W) - 1) begin : g_bad_dwell
      $error("dwell_counter: DWELL=%0d outside 1..2**CNT_W-1", DWELL);
   end

   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DWELL - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: clear has priority over increment; otherwise hold.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/mux4_scan_sequencer.sv
// Drives a 4:1 mux with a latched word, walks sel 0..3 with a fixed dwell,
// captures the mux output at the end of each dwell and checks it against
// the driven word.
module mux4_scan_sequencer
   import mux_seq_pkg::*;
#(
   parameter int DWELL = 10,
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   input  logic              out,
   output logic              d0,
   output logic              d1,
   output logic              d2,
   output logic              d3,
   output logic [1:0]        sel,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rx_word,
   output logic              match
);

   state_t            state_q;
   logic [DATA_W-1:0] d_q;
   logic [1:0]        sel_q;
   logic              busy_q;
   logic              done_q;
   logic [DATA_W-1:0] rx_q;
   logic              match_q;

   logic cnt_clr;
   logic cnt_en;
   logic cnt_tc;

   // The counter restarts when a scan is launched and whenever a dwell ends;
   // it only advances while scanning.
   assign cnt_clr = (state_q == ST_IDLE) ? start : cnt_tc;
   assign cnt_en  = (state_q == ST_SCAN);

   dwell_counter #(
      .CNT_W (CNT_W),
      .DWELL (DWELL)
   ) u_dwell (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .tc    (cnt_tc)
   );

   // Scan FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         d_q     <= '0;
         sel_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rx_q    <= '0;
         match_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  d_q     <= data_in;
                  sel_q   <= '0;
                  rx_q    <= '0;
                  match_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (cnt_tc) begin
                  rx_q[sel_q] <= out;
                  if (sel_q != SEL_LAST) begin
                     sel_q <= sel_q + 2'd1;
                  end else begin
                     // The last bit is still in flight, so compare using out directly.
                     match_q <= ({out, rx_q[2:0]} == d_q);
                     sel_q   <= '0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign d0      = d_q[0];
   assign d1      = d_q[1];
   assign d2      = d_q[2];
   assign d3      = d_q[3];
   assign sel     = sel_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign rx_word = rx_q;
   assign match   = match_q;

endmodule

// File: tb/tb_mux4_scan_sequencer.sv
// Directed bench for mux4_scan_sequencer: one DWELL=10 instance and one
// DWELL=1 instance, each closing the loop through a behavioural 4:1 mux.
module tb_mux4_scan_sequencer;

   logic       clk;
   logic       rst_n;
   logic       start_a;
   logic       start_b;
   logic [3:0] data_in;
   logic       force_zero;

   logic       out_a, d0_a, d1_a, d2_a, d3_a, busy_a, done_a, match_a;
   logic [1:0] sel_a;
   logic [3:0] rx_a;
   logic [3:0] dvec_a;

   logic       out_b, d0_b, d1_b, d2_b, d3_b, busy_b, done_b, match_b;
   logic [1:0] sel_b;
   logic [3:0] rx_b;
   logic [3:0] dvec_b;

   int tests;
   int fails;
   int pulses;

   assign dvec_a = {d3_a, d2_a, d1_a, d0_a};
   assign dvec_b = {d3_b, d2_b, d1_b, d0_b};
   assign out_a  = force_zero ? 1'b0 : dvec_a[sel_a];
   assign out_b  = dvec_b[sel_b];

   mux4_scan_sequencer #(.DWELL(10), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start_a), .data_in(data_in), .out(out_a),
      .d0(d0_a), .d1(d1_a), .d2(d2_a), .d3(d3_a), .sel(sel_a),
      .busy(busy_a), .done(done_a), .rx_word(rx_a), .match(match_a)
   );

   mux4_scan_sequencer #(.DWELL(1), .CNT_W(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_b), .data_in(data_in), .out(out_b),
      .d0(d0_b), .d1(d1_b), .d2(d2_b), .d3(d3_b), .sel(sel_b),
      .busy(busy_b), .done(done_b), .rx_word(rx_b), .match(match_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      start_a = 1'b1;
      start_b = 1'b1;
      data_in = 4'hF;
      force_zero = 1'b0;

      // 1: reset with start high
      step();
      step();
      chk("rst_d", dvec_a, 4'h0);
      chk("rst_sel", sel_a, 2'd0);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_done", done_a, 1'b0);
      chk("rst_rx", rx_a, 4'h0);
      chk("rst_match", match_a, 1'b0);
      chk("rst_busy_b", busy_b, 1'b0);
      rst_n = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      step();
      chk("idle_busy", busy_a, 1'b0);

      // 2: single scan of 1010
      data_in = 4'b1010;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      chk("s2_d", dvec_a, 4'b1010);
      for (int k = 0; k < 40; k++) begin
         chk("s2_sel", sel_a, k / 10);
         chk("s2_busy", busy_a, 1'b1);
         chk("s2_nodone", done_a, 1'b0);
         step();
      end
      chk("s2_done", done_a, 1'b1);
      chk("s2_busy_end", busy_a, 1'b0);
      chk("s2_rx", rx_a, 4'b1010);
      chk("s2_match", match_a, 1'b1);
      chk("s2_sel_end", sel_a, 2'd0);
      step();
      chk("s2_done_drop", done_a, 1'b0);
      chk("s2_rx_hold", rx_a, 4'b1010);
      chk("s2_d_hold", dvec_a, 4'b1010);

      // 3: start held high, back-to-back scans of 0101
      data_in = 4'b0101;
      start_a = 1'b1;
      step();
      pulses = 0;
      for (int k = 0; k < 39; k++) begin
         if (done_a) pulses++;
         step();
      end
      step();
      chk("s3_done1", done_a, 1'b1);
      chk("s3_rx1", rx_a, 4'b0101);
      chk("s3_match1", match_a, 1'b1);
      step();
      chk("s3_restart_busy", busy_a, 1'b1);
      chk("s3_restart_done", done_a, 1'b0);
      chk("s3_restart_match", match_a, 1'b0);
      chk("s3_restart_rx", rx_a, 4'b0000);
      for (int k = 0; k < 39; k++) begin
         if (done_a) pulses++;
         step();
      end
      step();
      chk("s3_extra_done", pulses, 0);
      chk("s3_done2", done_a, 1'b1);
      chk("s3_rx2", rx_a, 4'b0101);
      chk("s3_match2", match_a, 1'b1);
      start_a = 1'b0;
      step();
      chk("s3_idle_done", done_a, 1'b0);
      chk("s3_idle_busy", busy_a, 1'b0);

      // 4: mux output stuck at 0
      force_zero = 1'b1;
      data_in = 4'b1010;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      for (int k = 0; k < 39; k++) step();
      chk("s4_done_early", done_a, 1'b0);
      chk("s4_busy39", busy_a, 1'b1);
      step();
      chk("s4_done", done_a, 1'b1);
      chk("s4_rx", rx_a, 4'b0000);
      chk("s4_match", match_a, 1'b0);
      force_zero = 1'b0;
      step();

      // 5: start during scan is ignored
      data_in = 4'b1010;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      for (int k = 0; k < 16; k++) step();
      data_in = 4'b1111;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      chk("s5_d_kept", dvec_a, 4'b1010);
      chk("s5_sel17", sel_a, 2'd1);
      chk("s5_busy17", busy_a, 1'b1);
      for (int k = 0; k < 22; k++) step();
      chk("s5_done_early", done_a, 1'b0);
      step();
      chk("s5_done", done_a, 1'b1);
      chk("s5_rx", rx_a, 4'b1010);
      chk("s5_match", match_a, 1'b1);
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (busy_a) pulses++;
      end
      chk("s5_no_second", pulses, 0);

      // 6: reset mid-scan, then a normal scan
      data_in = 4'b1010;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      for (int k = 0; k < 14; k++) step();
      rst_n = 1'b0;
      step();
      chk("s6_rst_d", dvec_a, 4'h0);
      chk("s6_rst_sel", sel_a, 2'd0);
      chk("s6_rst_busy", busy_a, 1'b0);
      chk("s6_rst_done", done_a, 1'b0);
      chk("s6_rst_rx", rx_a, 4'h0);
      chk("s6_rst_match", match_a, 1'b0);
      rst_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 30; k++) begin
         step();
         if (done_a || busy_a) pulses++;
      end
      chk("s6_no_done", pulses, 0);
      data_in = 4'b0110;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      for (int k = 0; k < 40; k++) step();
      chk("s6_done", done_a, 1'b1);
      chk("s6_rx", rx_a, 4'b0110);
      chk("s6_match", match_a, 1'b1);

      // 6b: DWELL=1 variant, 4-cycle scan
      data_in = 4'b1001;
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("d1_sel", sel_b, k);
         chk("d1_busy", busy_b, 1'b1);
         step();
      end
      chk("d1_done", done_b, 1'b1);
      chk("d1_busy_end", busy_b, 1'b0);
      chk("d1_rx", rx_b, 4'b1001);
      chk("d1_match", match_b, 1'b1);
      step();
      chk("d1_done_drop", done_b, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
